// File: rtl/serial_sub_ctrl_if.sv
// Handshake and data bundle for the bit-serial subtraction controller.
// The requester drives start/a/b; the controller returns busy/done/diff/borrow_out.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, with the
// borrow carried between bits in a flop. Result is held until the next one completes.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_sub_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sd_q, diff_q;
  logic             br_q, borrow_q, busy_q, done_q;
  logic [CntW-1:0]  cnt_q;

  logic             cell_a, cell_b, cell_cin, cell_diff, cell_borrow;
  logic [WIDTH-1:0] sd_shift;

  // Full-subtractor cell: A - B - Cin.
  always_comb begin
    cell_a      = sa_q[0];
    cell_b      = sb_q[0];
    cell_cin    = br_q;
    cell_diff   = cell_a ^ cell_b ^ cell_cin;
    cell_borrow = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_cin);
    sd_shift    = {cell_diff, sd_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        // The done cycle also samples start so a held request sustains one
        // operation every WIDTH+1 clocks.
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sd_q  <= sd_shift;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= cell_borrow;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            diff_q   <= sd_shift;
            borrow_q <= cell_borrow;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule
